// File: rtl/multiword_add_sequencer.sv
// Purpose : adds two WIDTH*NUM_WORDS-bit operands with a single WIDTH-bit slice, one word per cycle.
// Latency : accept edge T -> out_valid from T+NUM_WORDS; one op per NUM_WORDS+2 cycles.
// Backpr. : in_ready low from accept until the result is taken; result held while out_ready=0.
//
// Ports: clk/rst_n (async active-low); in_valid/in_ready + a, b, cin operand stream;
//        out_valid/out_ready + sum, cout, ovf result stream; busy high in RUN or DONE.
// Build option: SEQ_SUBTRACT_EN adds a 'sub' input; sub=1 computes a - b (cout=1 -> no borrow).
module multiword_add_sequencer #(
    parameter int WIDTH     = 4,
    parameter int NUM_WORDS = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH*NUM_WORDS-1:0]   a,
    input  logic [WIDTH*NUM_WORDS-1:0]   b,
    input  logic                         cin,
`ifdef SEQ_SUBTRACT_EN
    input  logic                         sub,
`endif
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH*NUM_WORDS-1:0]   sum,
    output logic                         cout,
    output logic                         ovf,
    output logic                         busy
);

    localparam int N    = WIDTH * NUM_WORDS;
    localparam int IDXW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [N-1:0]      a_q;
    logic [N-1:0]      b_q;     // already inverted for subtraction
    logic              carry;   // carry chained from word idx-1 into word idx
    logic [IDXW-1:0]   idx;

    logic [WIDTH-1:0]  a_w;
    logic [WIDTH-1:0]  b_w;
    logic [WIDTH:0]    slice;
    logic              msb_cin;
    logic              last;

    // The one shared slice: WIDTH+1-bit add so the carry is never dropped.
    always_comb begin
        a_w     = a_q[idx*WIDTH +: WIDTH];
        b_w     = b_q[idx*WIDTH +: WIDTH];
        slice   = {1'b0, a_w} + {1'b0, b_w} + {{WIDTH{1'b0}}, carry};
        // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ cin.
        msb_cin = a_w[WIDTH-1] ^ b_w[WIDTH-1] ^ slice[WIDTH-1];
        last    = (idx == IDXW'(NUM_WORDS - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            carry     <= 1'b0;
            idx       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_q <= a;
`ifdef SEQ_SUBTRACT_EN
                        // a - b = a + ~b + 1; cin has no meaning for subtraction.
                        b_q   <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
`else
                        b_q   <= b;
                        carry <= cin;
`endif
                        idx      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    sum[idx*WIDTH +: WIDTH] <= slice[WIDTH-1:0];
                    carry                   <= slice[WIDTH];
                    if (last) begin
                        cout      <= slice[WIDTH];
                        ovf       <= msb_cin ^ slice[WIDTH];
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + IDXW'(1);
                    end
                end
                DONE: begin
                    // in_ready rises only after the handoff edge, so no new
                    // operand is taken in the same cycle the result leaves.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multiword_add_sequencer.sv
module tb_multiword_add_sequencer;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
`ifdef SEQ_SUBTRACT_EN
    logic        sub;
`endif
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        busy;

    int total = 0;
    int bad   = 0;

    multiword_add_sequencer #(.WIDTH(4), .NUM_WORDS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef SEQ_SUBTRACT_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", nm, got, exp);
        end
    endtask

    // Present operands, wait (bounded) for in_ready, hand them over, then scramble inputs.
    task automatic start_op(input vec_t v, input string nm);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        a        = v.a;
        b        = v.b;
        cin      = v.cin;
`ifdef SEQ_SUBTRACT_EN
        sub      = v.sub;
`endif
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = 16'($urandom);
        b        = 16'($urandom);
        cin      = 1'($urandom);
`ifdef SEQ_SUBTRACT_EN
        sub      = 1'($urandom);
`endif
    endtask

    // Count edges after the accept edge until out_valid; -1 if it never comes.
    task automatic wait_valid(output int lat);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int lat;
        start_op(v, nm);
        wait_valid(lat);
        check({nm, "_latency"}, 32'(lat), 32'd4);
        check({nm, "_sum"},  {16'd0, sum},  {16'd0, v.s});
        check({nm, "_cout"}, {31'd0, cout}, {31'd0, v.co});
        check({nm, "_ovf"},  {31'd0, ovf},  {31'd0, v.ov});
        take_result();
    endtask

    initial begin
        vec_t vecs[$];
        vec_t v;
        int   lat;
        int   pulses;

        //                a         b         cin   sub   sum       co    ov
        vecs.push_back('{16'h0005, 16'h0003, 1'b0, 1'b0, 16'h0008, 1'b0, 1'b0});
        vecs.push_back('{16'h0005, 16'h0003, 1'b1, 1'b0, 16'h0009, 1'b0, 1'b0});
        vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0});
        vecs.push_back('{16'h000F, 16'h0001, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0});
        vecs.push_back('{16'h0007, 16'h0008, 1'b0, 1'b0, 16'h000F, 1'b0, 1'b0});
        vecs.push_back('{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1});
        vecs.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1});
        vecs.push_back('{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0});
        vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0});
        vecs.push_back('{16'hABCD, 16'h5433, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0});
`ifdef SEQ_SUBTRACT_EN
        vecs.push_back('{16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0});
        vecs.push_back('{16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0});
        vecs.push_back('{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1});
`endif

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 16'h0;
        b         = 16'h0;
        cin       = 1'b0;
`ifdef SEQ_SUBTRACT_EN
        sub       = 1'b0;
`endif
        #12;
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_sum",       {16'd0, sum},       32'd0);
        check("rst_cout",      {31'd0, cout},      32'd0);
        check("rst_ovf",       {31'd0, ovf},       32'd0);
        check("rst_busy",      {31'd0, busy},      32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure: result held for 5 cycles; in_valid meanwhile must be ignored.
        v = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        start_op(v, "bp");
        wait_valid(lat);
        check("bp_latency", 32'(lat), 32'd4);
        in_valid = 1'b1;
        a        = 16'hFFFF;
        b        = 16'hFFFF;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp_hold%0d_sum", k),   {16'd0, sum},       32'h5555);
            check($sformatf("bp_hold%0d_cout", k),  {31'd0, cout},      32'd0);
            check($sformatf("bp_hold%0d_valid", k), {31'd0, out_valid}, 32'd1);
            check($sformatf("bp_hold%0d_ready", k), {31'd0, in_ready},  32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_handoff_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_after_out_valid", {31'd0, out_valid}, 32'd0);
        check("bp_after_in_ready",  {31'd0, in_ready},  32'd1);
        check("bp_after_busy",      {31'd0, busy},      32'd0);
        run_vec(vecs[0], "bp_next");

        // Reset while RUN is at idx=2 (two words already written).
        v = '{16'h5555, 16'h2222, 1'b0, 1'b0, 16'h7777, 1'b0, 1'b0};
        start_op(v, "rstmid");
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rstmid_busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rstmid_sum",       {16'd0, sum},       32'd0);
        check("rstmid_cout",      {31'd0, cout},      32'd0);
        check("rstmid_ovf",       {31'd0, ovf},       32'd0);
        check("rstmid_busy",      {31'd0, busy},      32'd0);
        check("rstmid_in_ready",  {31'd0, in_ready},  32'd1);
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            if (k == 2) begin
                @(negedge clk);
                rst_n = 1'b1;
            end
            @(posedge clk);
            #1;
            if (out_valid) pulses++;
        end
        check("rstmid_no_out_valid", 32'(pulses), 32'd0);
`ifdef SEQ_SUBTRACT_EN
        run_vec(vecs[10], "rstmid_next_sub");
`else
        run_vec(vecs[0], "rstmid_next");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
